// File: rtl/syscall_ctrl_if.sv
// Syscall controller bus: decoder/register-file inputs toward the controller,
// and the held CPU state and display outputs back from it.
interface syscall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             syscall;
  logic [31:0]      v0;
  logic [31:0]      a0;
  logic             go;
  logic             stall;
  logic             halted;
  logic [31:0]      show_data;
  logic             show_valid;
  logic [CNT_W-1:0] sys_cnt;
  logic [1:0]       state;

  modport master (
    output syscall, v0, a0, go,
    input  stall, halted, show_data, show_valid, sys_cnt, state
  );

  modport slave (
    input  syscall, v0, a0, go,
    output stall, halted, show_data, show_valid, sys_cnt, state
  );
endinterface

// File: rtl/syscall_ctrl.sv
// Turns the combinational syscall decision into a held CPU state: a timed
// display stall for the show code, otherwise a halt until the operator presses go.
module syscall_ctrl #(
  parameter logic [31:0] SHOW_CODE   = 32'h0000_0022,
  parameter int          SHOW_CYCLES = 4,
  parameter int          CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  syscall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SHOW   = 2'd1,
    HALT   = 2'd2,
    UNUSED = 2'd3
  } state_t;

  localparam logic [7:0] DWELL_INIT = 8'(SHOW_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       dwell_q, dwell_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_q;
  logic             go_rise;
  logic             accept;

  assign go_rise = bus.go & ~go_q;
  assign accept  = (state_q == RUN) & bus.syscall;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    data_d  = data_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (bus.v0 == SHOW_CODE) begin
            state_d = SHOW;
            data_d  = bus.a0;
            valid_d = 1'b1;
            dwell_d = DWELL_INIT;
          end else begin
            state_d = HALT;
          end
        end
      end
      SHOW: begin
        if (dwell_q == 8'd0) state_d = RUN;
        else                 dwell_d = dwell_q - 8'd1;
      end
      HALT: begin
        if (go_rise) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // go_q resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      dwell_q <= 8'd0;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      go_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      go_q    <= bus.go;
    end
  end

  assign bus.stall      = (state_q != RUN);
  assign bus.halted     = (state_q == HALT);
  assign bus.show_data  = data_q;
  assign bus.show_valid = valid_q;
  assign bus.sys_cnt    = cnt_q;
  assign bus.state      = state_q;

endmodule
